pla_shift_sequencer: RTL and testbench

//   Multi-pass controller for the 16-bit combinational arithmetic-right barrel shifter (shift 0..7).
//   - Accepts a word and a 4-bit shift amount (0..15) over valid/ready.
//   - Drives the shared shifter once per cycle with steps of at most 7, registering each partial result.
//   - Returns the final word over a valid/ready output channel.

---
 rtl/pla_shift_sequencer.sv | 128 ++++++++++++
 tb/tb_pla_shift_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pla_shift_sequencer.sv
// pla_shift_sequencer
//   Multi-pass controller for a shared 16-bit combinational arithmetic-right
//   barrel shifter that can shift at most MAX_STEP places per pass. A request
//   (word + total amount 0..15) is split into passes of at most MAX_STEP. Each
//   partial result is registered, and the final word is returned over
//   valid/ready.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     flush               synchronous abort of any in-flight operation
//     in_valid/in_ready   request handshake; in_data operand, in_amt amount
//     out_valid/out_ready result handshake; out_data result
//     busy                high while an operation is in SHIFT or DONE
//     sh_amt/sh_data      drive the shared shifter (zero outside SHIFT)
//     sh_result           shifter output, combinational in the same cycle
//
//   Optional feature: define SHIFT_SEQ_STATS_EN to add stat_clr, stat_ops
//   (completed output handshakes) and stat_passes (SHIFT cycles).
module pla_shift_sequencer #(
    parameter int DATA_W   = 16,
    parameter int AMT_W    = 4,
    parameter int MAX_STEP = 7,
    localparam int SEL_W   = $clog2(MAX_STEP + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [SEL_W-1:0]  sh_amt,
    output logic [DATA_W-1:0] sh_data,
`ifdef SHIFT_SEQ_STATS_EN
    input  logic              stat_clr,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_passes,
`endif
    input  logic [DATA_W-1:0] sh_result
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [AMT_W-1:0] STEP_MAX = AMT_W'(MAX_STEP);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] data_q;
    logic [AMT_W-1:0]  rem_q;
    logic [AMT_W-1:0]  step;
    logic              last_pass;
    logic              accept;

    assign step      = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;
    assign last_pass = (rem_q <= STEP_MAX);
    // flush wins over a same-cycle request
    assign accept    = (state_q == IDLE) && in_valid && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        sh_amt    = '0;
        sh_data   = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) state_d = SHIFT;
            end
            SHIFT: begin
                busy    = 1'b1;
                sh_data = data_q;
                sh_amt  = SEL_W'(step);
                if (last_pass) state_d = DONE;
            end
            DONE: begin
                busy = 1'b1;
                // a flushed result must not be seen as handshaken
                out_valid = !flush;
                out_data  = data_q;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            rem_q  <= '0;
        end else if (!flush) begin
            if (accept) begin
                data_q <= in_data;
                rem_q  <= in_amt;
            end else if (state_q == SHIFT) begin
                data_q <= sh_result;
                rem_q  <= rem_q - step;
            end
        end
    end

`ifdef SHIFT_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops    <= '0;
            stat_passes <= '0;
        end else if (stat_clr) begin
            stat_ops    <= '0;
            stat_passes <= '0;
        end else begin
            if (out_valid && out_ready) stat_ops    <= stat_ops + 16'd1;
            if (state_q == SHIFT)       stat_passes <= stat_passes + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pla_shift_sequencer.sv
module tb_pla_shift_sequencer;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_data = 0;
    logic [3:0]  in_amt = 0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [15:0] out_data;
    logic        busy;
    logic [2:0]  sh_amt;
    logic [15:0] sh_data;
    logic [15:0] sh_result;
`ifdef SHIFT_SEQ_STATS_EN
    logic        stat_clr = 0;
    logic [15:0] stat_ops;
    logic [15:0] stat_passes;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // behavioural shared shifter
    assign sh_result = $unsigned($signed(sh_data) >>> sh_amt);

    pla_shift_sequencer dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .sh_amt(sh_amt), .sh_data(sh_data),
`ifdef SHIFT_SEQ_STATS_EN
        .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_passes(stat_passes),
`endif
        .sh_result(sh_result)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] asr(input logic [15:0] d, input int n);
        logic signed [15:0] s;
        s = d;
        return $unsigned(s >>> n);
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("rdy_timeout", 0, 1);
    endtask

    // issue one request (at a negedge), follow every pass, hold backpressure, complete
    task automatic run_op(input logic [15:0] d, input logic [3:0] a, input logic [15:0] exp,
                          input int bp, input bit clr_at_hs);
        int rem, done_sh, step, np;
        wait_ready();
        in_valid = 1; in_data = d; in_amt = a; out_ready = 0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; in_data = $urandom; in_amt = 4'($urandom);
        np = (a == 0) ? 1 : (int'(a) + 6) / 7;
        rem = a; done_sh = 0;
        for (int k = 0; k < np; k++) begin
            step = (rem > 7) ? 7 : rem;
            chk("sh_amt", 32'(sh_amt), 32'(step));
            chk("sh_data", 32'(sh_data), 32'(asr(d, done_sh)));
            chk("shift_flags", {busy, in_ready, out_valid}, 3'b100);
            rem -= step; done_sh += step;
            @(posedge clk);
            @(negedge clk);
        end
        chk("out_valid", 32'(out_valid), 1);
        chk("out_data", 32'(out_data), 32'(exp));
        for (int k = 0; k < bp; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_hold", {out_valid, in_ready, busy, out_data}, {3'b101, exp});
        end
        out_ready = 1;
`ifdef SHIFT_SEQ_STATS_EN
        stat_clr = clr_at_hs;
`endif
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
`ifdef SHIFT_SEQ_STATS_EN
        stat_clr = 0;
`endif
        chk("post_hs", {out_valid, in_ready, busy, sh_amt}, {3'b010, 3'd0});
    endtask

    initial begin
        logic [15:0] d;
        logic [3:0]  a;
        #12;
        chk("rst_state", {in_ready, out_valid, busy, sh_amt, sh_data, out_data},
            {3'b100, 3'd0, 16'd0, 16'd0});
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

`ifdef SHIFT_SEQ_STATS_EN
        chk("stat_rst", {stat_ops, stat_passes}, 0);
`endif
        // directed scenarios 1-3 (4 ops, 8 passes)
        run_op(16'h8000, 4'd15, 16'hFFFF, 0, 0);
        run_op(16'h4000, 4'd14, 16'h0001, 0, 0);
        run_op(16'h7FFF, 4'd9,  16'h003F, 0, 0);
        run_op(16'h1234, 4'd0,  16'h1234, 2, 0);
`ifdef SHIFT_SEQ_STATS_EN
        chk("stat_ops", 32'(stat_ops), 4);
        chk("stat_passes", 32'(stat_passes), 8);
        run_op(16'h00F0, 4'd3, 16'h001E, 0, 1);
        chk("stat_clr", {stat_ops, stat_passes}, 0);
`endif
        // backpressure
        run_op(16'hA5A5, 4'd5, asr(16'hA5A5, 5), 5, 0);

        // randomized ops against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            d = 16'($urandom);
            a = 4'($urandom);
            run_op(d, a, asr(d, int'(a)), int'($urandom_range(0, 3)), 0);
        end

        // flush on second SHIFT cycle of amt=15
        wait_ready();
        in_valid = 1; in_data = 16'h8000; in_amt = 4'd15;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("pre_flush_amt", 32'(sh_amt), 7);
        flush = 1;
        @(posedge clk);
        @(negedge clk);
        flush = 0;
        chk("flush_idle", {in_ready, busy, out_valid}, 3'b100);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("flush_no_out", {out_valid, busy}, 2'b00);
        end

        // flush in IDLE with a pending request: not accepted
        in_valid = 1; flush = 1; in_data = 16'h1111; in_amt = 4'd3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; flush = 0;
        chk("flush_idle_req", {busy, in_ready}, 2'b01);

        // flush while holding a result in DONE
        in_valid = 1; in_data = 16'h0F00; in_amt = 4'd4;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        @(posedge clk);
        @(negedge clk);
        chk("done_valid", {out_valid, out_data}, {1'b1, 16'h00F0});
        flush = 1;
        @(posedge clk);
        @(negedge clk);
        flush = 0;
        chk("flush_done", {out_valid, busy, in_ready}, 3'b001);

        // reset pulse mid-SHIFT
        in_valid = 1; in_data = 16'hFFFF; in_amt = 4'd15;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0;
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 0;
        #1;
        chk("mid_rst", {in_ready, out_valid, busy, sh_amt, sh_data, out_data},
            {3'b100, 3'd0, 16'd0, 16'd0});
        @(negedge clk);
        rst_n = 1;
        run_op(16'hC000, 4'd2, 16'hF000, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
